// File: rtl/pulse_req_sync_src.sv
// Source side of a pulse crossing: turns clk-domain event pulses into a four-phase
// req/ack level handshake, queueing events that arrive while a transfer is in flight.
module pulse_req_sync_src #(
   parameter int CNT_W       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  logic             ack_async,
   output logic             req_out,
   output logic             busy,
   output logic             done,
   output logic             drop,
   output logic [CNT_W-1:0] pending
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_ACK_LOW = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   ack_s;

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] pending_reg, pending_next;
   logic             req_reg, done_reg, done_next, drop_reg, drop_next;
   logic             inc, dec;

   // ack_async is sampled only by the first stage of this chain
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) sync_reg[0] <= 1'b0;
               else        sync_reg[0] <= ack_async;
            end
         end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) sync_reg[gi] <= 1'b0;
               else        sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign ack_s = sync_reg[SYNC_STAGES-1];

   always_comb begin
      state_next = state_reg;
      inc        = 1'b0;
      dec        = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (pulse_in) state_next = ST_REQ;
         end
         ST_REQ: begin
            inc = pulse_in;
            if (ack_s) state_next = ST_ACK_LOW;
         end
         ST_ACK_LOW: begin
            if (!ack_s) begin
               done_next = 1'b1;
               if (pending_reg != '0) begin
                  state_next = ST_REQ;
                  dec        = 1'b1;
                  inc        = pulse_in;
               end else if (pulse_in) begin
                  // new pulse starts the next transfer directly, never touching the queue
                  state_next = ST_REQ;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               inc = pulse_in;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      pending_next = pending_reg;
      drop_next    = 1'b0;
      if (inc && !dec) begin
         if (pending_reg == CNT_MAX) drop_next = 1'b1;
         else                        pending_next = pending_reg + 1'b1;
      end else if (dec && !inc) begin
         pending_next = pending_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         pending_reg <= '0;
         req_reg     <= 1'b0;
         done_reg    <= 1'b0;
         drop_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         req_reg     <= (state_next == ST_REQ);
         done_reg    <= done_next;
         drop_reg    <= drop_next;
      end
   end

   assign req_out = req_reg;
   assign done    = done_reg;
   assign drop    = drop_reg;
   assign pending = pending_reg;
   assign busy    = (state_reg != ST_IDLE) | (pending_reg != '0);

endmodule

// File: tb/tb_pulse_req_sync_src.sv
// Directed bench for pulse_req_sync_src: cycle table for the basic handshake plus
// hand-written sequences for queueing, saturation, the exit-cycle pulse and async reset.
module tb_pulse_req_sync_src;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             pulse_in;
   logic             ack_async;
   logic             req_out, busy, done, drop;
   logic [CNT_W-1:0] pending;

   // optional responder: ack follows req_out three edges later
   logic       echo_en   = 1'b0;
   logic       ack_force = 1'b0;
   logic [2:0] req_hist  = '0;

   int checks = 0;
   int errors = 0;

   // per-sequence statistics
   int   st_pmax, st_reqs, st_dones, st_drops, st_decs, st_prev_pend;
   logic st_prev_req;

   typedef struct {
      logic pulse;
      logic ack;
      logic req;
      logic bsy;
      logic dn;
      logic drp;
      int   pend;
   } vec_t;

   vec_t vecs[20];

   always #5 clk = ~clk;

   always @(posedge clk) req_hist <= {req_hist[1:0], req_out};
   assign ack_async = echo_en ? req_hist[2] : ack_force;

   pulse_req_sync_src #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pulse_in  (pulse_in),
      .ack_async (ack_async),
      .req_out   (req_out),
      .busy      (busy),
      .done      (done),
      .drop      (drop),
      .pending   (pending)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      st_pmax = 0; st_reqs = 0; st_dones = 0; st_drops = 0; st_decs = 0;
      st_prev_pend = int'(pending);
      st_prev_req  = req_out;
   endtask

   task automatic step();
      tick();
      if (req_out && !st_prev_req) st_reqs++;
      st_prev_req = req_out;
      if (done) st_dones++;
      if (drop) st_drops++;
      if (int'(pending) < st_prev_pend) st_decs++;
      st_prev_pend = int'(pending);
      if (int'(pending) > st_pmax) st_pmax = int'(pending);
   endtask

   task automatic do_reset();
      pulse_in  = 1'b0;
      echo_en   = 1'b0;
      ack_force = 1'b0;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int wait_cnt;
      int done_seen;

      // basic handshake, then a pulse queued in REQ and ACK_LOW with inc+dec on exit
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
      vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2};
      vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2};

      // reset held with pulse_in toggling
      rst_n = 1'b0; pulse_in = 1'b0;
      #2;
      for (int i = 0; i < 4; i++) begin
         pulse_in = ~pulse_in;
         tick();
         check($sformatf("rst_req[%0d]", i), req_out, 0);
         check($sformatf("rst_busy[%0d]", i), busy, 0);
         check($sformatf("rst_done_drop[%0d]", i), {done, drop}, 0);
         check($sformatf("rst_pend[%0d]", i), pending, 0);
      end
      pulse_in = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("idle_after_rst[%0d]", i), {req_out, busy}, 0);
      end
      $display("reset sequence: req_out=%0b busy=%0b pending=%0d", req_out, busy, pending);

      // table-driven cycle vectors
      for (int i = 0; i < 20; i++) begin
         pulse_in  = vecs[i].pulse;
         ack_force = vecs[i].ack;
         tick();
         check($sformatf("vec%0d_req", i), req_out, vecs[i].req);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
         check($sformatf("vec%0d_done", i), done, vecs[i].dn);
         check($sformatf("vec%0d_drop", i), drop, vecs[i].drp);
         check($sformatf("vec%0d_pend", i), pending, vecs[i].pend);
         $display("vec %0d: pulse=%0b ack=%0b -> req=%0b busy=%0b done=%0b drop=%0b pend=%0d",
                  i, vecs[i].pulse, vecs[i].ack, req_out, busy, done, drop, pending);
      end

      // queueing: five back-to-back pulses from IDLE with the responder echoing
      do_reset();
      echo_en = 1'b1;
      clear_stats();
      for (int i = 0; i < 5; i++) begin
         pulse_in = 1'b1;
         step();
      end
      pulse_in = 1'b0;
      for (int i = 0; i < 300; i++) step();
      check("queue_pend_peak", st_pmax, 4);
      check("queue_req_periods", st_reqs, 5);
      check("queue_dones", st_dones, 5);
      check("queue_decrements", st_decs, 4);
      check("queue_drops", st_drops, 0);
      check("queue_idle", {busy, req_out}, 0);
      $display("queue: peak=%0d reqs=%0d dones=%0d decs=%0d drops=%0d",
               st_pmax, st_reqs, st_dones, st_decs, st_drops);

      // saturation: 20 pulses with ack held low
      do_reset();
      clear_stats();
      for (int i = 0; i < 20; i++) begin
         pulse_in = 1'b1;
         step();
      end
      pulse_in = 1'b0;
      check("sat_pend", pending, 15);
      check("sat_drops", st_drops, 4);
      check("sat_req", req_out, 1);
      $display("saturation: pending=%0d drops=%0d req=%0b", pending, st_drops, req_out);
      echo_en = 1'b1;
      clear_stats();
      for (int i = 0; i < 600; i++) step();
      check("sat_transfers", st_dones, 16);
      check("sat_idle", {busy, pending}, 0);
      check("sat_no_more_drop", st_drops, 0);
      $display("saturation drain: dones=%0d busy=%0b", st_dones, busy);

      // pulse arriving in the exact ACK_LOW exit cycle with nothing queued
      do_reset();
      pulse_in = 1'b1;
      tick();
      pulse_in  = 1'b0;
      ack_force = 1'b1;
      wait_cnt = 0;
      while (req_out && wait_cnt < 10) begin
         tick();
         wait_cnt++;
      end
      check("simul_req_fell", req_out, 0);
      ack_force = 1'b0;
      tick();
      tick();
      check("simul_no_early_done", done, 0);
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      check("simul_done", done, 1);
      check("simul_req", req_out, 1);
      check("simul_pend", pending, 0);
      tick();
      check("simul_done_one_cycle", done, 0);
      $display("exit-cycle pulse: done=%0b req=%0b pending=%0d", done, req_out, pending);

      // asynchronous reset while in REQ with three queued events
      do_reset();
      for (int i = 0; i < 4; i++) begin
         pulse_in = 1'b1;
         tick();
      end
      pulse_in = 1'b0;
      check("midrst_pre_pend", pending, 3);
      check("midrst_pre_req", req_out, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_req", req_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_pend", pending, 0);
      tick();
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done || req_out) done_seen++;
      end
      check("midrst_no_done_after", done_seen, 0);
      $display("mid-transfer reset: req=%0b busy=%0b pending=%0d later_activity=%0d",
               req_out, busy, pending, done_seen);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
